// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller wrapping a combinational 16-bit ALU
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake; instr carries
//                            [15]=mode [14:11]=select [10:8]=rd [7:5]=ra [4:2]=rb
//                            [1]=use_carry [0]=wb_en
//   ld_en/ld_addr/ld_data    register file load, honoured only while idle
//   dbg_addr/dbg_data        combinational register file read
//   alu_in_a/alu_in_b        operands regfile[ra]/regfile[rb] of the latched instruction
//   alu_select/alu_mode      ALU function select and mode
//   alu_carry_in             sticky carry when use_carry is set, else 0
//   alu_result/alu_carry_out/alu_compare  ALU outputs captured at the end of EXEC
//   done                     one-cycle pulse in the writeback cycle
//   result                   last captured ALU result
//   carry_flag/cmp_flag      sticky carry (arithmetic mode only) and compare flags
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    output logic [3:0]       alu_select,
    output logic             alu_mode,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_compare,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             cmp_flag
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state, state_nx;
    logic [15:0] instr_q;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] result_q;
    logic carry_q, cmp_q;
    logic mode_q, use_carry_q, wb_en_q;
    logic [3:0] select_q;
    logic [2:0] rd_q, ra_q, rb_q;
    assign {mode_q, select_q, rd_q, ra_q, rb_q, use_carry_q, wb_en_q} = instr_q;
    assign dbg_data = rf[dbg_addr];
    assign alu_in_a = rf[ra_q];
    assign alu_in_b = rf[rb_q];
    assign alu_select = select_q;
    assign alu_mode = mode_q;
    assign alu_carry_in = use_carry_q & carry_flag;
    assign result = result_q;
    always_comb begin
        instr_ready = state == IDLE;
        done = state == WB;
        state_nx = state == IDLE ? (instr_valid ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            instr_q <= '0;
            result_q <= '0;
            carry_q <= 1'b0;
            cmp_q <= 1'b0;
            carry_flag <= 1'b0;
            cmp_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid)
                instr_q <= instr;
            if (state == EXEC) begin
                result_q <= alu_result;
                carry_q <= alu_carry_out;
                cmp_q <= alu_compare;
            end
            if (state == WB) begin
                cmp_flag <= cmp_q;
                if (mode_q)
                    carry_flag <= carry_q;
            end
        end
    end
    // Loads and writebacks live in mutually exclusive states, so one write port suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (state == IDLE && ld_en) begin
            rf[ld_addr] <= ld_data;
        end else if (state == WB && wb_en_q) begin
            rf[rd_q] <= result_q;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a behavioural model
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0;
    logic instr_ready;
    logic [15:0] instr = '0;
    logic ld_en = 1'b0;
    logic [2:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [2:0] dbg_addr = '0;
    logic [15:0] dbg_data, alu_in_a, alu_in_b, alu_result, result;
    logic [3:0] alu_select;
    logic alu_mode, alu_carry_in, alu_carry_out, alu_compare, done, carry_flag, cmp_flag;
    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    int ndone = 0;
    logic [15:0] m_rf [8];
    logic m_c = 1'b0;
    logic m_cmp = 1'b0;
    logic [15:0] m_res = '0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select), .alu_mode(alu_mode),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .alu_compare(alu_compare), .done(done), .result(result), .carry_flag(carry_flag), .cmp_flag(cmp_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        if (done) ndone++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    // Stand-in ALU: logic functions in mode 0, add (select 1001) or subtract in mode 1.
    function automatic logic [17:0] alu_f(input logic m, input logic [3:0] s, input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] sum;
        if (m)
            sum = {1'b0, a} + {1'b0, (s == 4'b1001) ? b : ~b} + {16'd0, ci};
        else
            sum = {1'b0, s == 4'b1011 ? a & b : s == 4'b1110 ? a | b : s == 4'b0110 ? a ^ b : ~a};
        return {a == b, sum};
    endfunction
    assign {alu_compare, alu_carry_out, alu_result} = alu_f(alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_c = 1'b0;
        m_cmp = 1'b0;
        m_res = '0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("dbg_reg", {16'd0, dbg_data}, {16'd0, m_rf[i]});
        end
    endtask

    // Entered mid-cycle in IDLE; returns mid-cycle in the IDLE cycle following WB.
    task automatic run_instr(input logic [15:0] w, input bit hold, input logic [15:0] nxt,
                             input bit ld_acc, input bit ld_exec, input logic [2:0] la, input logic [15:0] ldv);
        logic [15:0] a, b;
        logic ci;
        logic [17:0] r;
        instr_valid = 1'b1;
        instr = w;
        ld_en = ld_acc;
        ld_addr = la;
        ld_data = ldv;
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        if (ld_acc) m_rf[la] = ldv;
        a = m_rf[w[7:5]];
        b = m_rf[w[4:2]];
        ci = w[1] & m_c;
        r = alu_f(w[15], w[14:11], a, b, ci);
        tick();
        instr_valid = hold;
        instr = nxt;
        ld_en = ld_exec;
        chk("ready_exec", {31'd0, instr_ready}, 32'd0);
        chk("done_exec", {31'd0, done}, 32'd0);
        chk("alu_ab", {alu_in_a, alu_in_b}, {a, b});
        chk("alu_ctl", {26'd0, alu_mode, alu_select, alu_carry_in}, {26'd0, w[15], w[14:11], ci});
        tick();
        ld_en = 1'b0;
        chk("done_wb", {30'd0, done, instr_ready}, 32'd2);
        chk("result_wb", {16'd0, result}, {16'd0, r[15:0]});
        m_res = r[15:0];
        if (w[0]) m_rf[w[10:8]] = r[15:0];
        m_cmp = r[17];
        if (w[15]) m_c = r[16];
        tick();
        chk("idle_after", {30'd0, done, instr_ready}, 32'd1);
        chk("flags", {14'd0, carry_flag, cmp_flag, result}, {14'd0, m_c, m_cmp, m_res});
    endtask

    initial begin
        int t0, t1, nd;
        logic [15:0] w;
        model_reset();
        #1;
        chk("reset_out", {29'd0, instr_ready, done, carry_flag}, 32'd4);
        chk("reset_alu", {alu_in_a, alu_in_b}, 32'd0);
        chk("reset_res", {15'd0, cmp_flag, result}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_regs();
        tick();

        load(3'd1, 16'h00F0);
        load(3'd2, 16'h0FF0);
        t0 = cyc;
        run_instr({1'b0, 4'b1011, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1}, 0, 16'h0, 0, 0, 3'd0, 16'h0);
        chk("and_latency", 32'(cyc - t0), 32'd3);
        dbg_addr = 3'd3;
        #1;
        chk("and_r3", {16'd0, dbg_data}, 32'h00F0);
        chk("and_carry", {31'd0, carry_flag}, 32'd0);
        tick();

        load(3'd4, 16'hFFFF);
        load(3'd5, 16'h0001);
        run_instr({1'b1, 4'b1001, 3'd6, 3'd4, 3'd5, 1'b0, 1'b1}, 0, 16'h0, 0, 0, 3'd0, 16'h0);
        chk("add_res_carry", {15'd0, carry_flag, result}, {15'd0, 1'b1, 16'h0000});
        tick();
        run_instr({1'b0, 4'b0110, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0}, 0, 16'h0, 0, 0, 3'd0, 16'h0);
        chk("carry_hold", {30'd0, carry_flag, cmp_flag}, 32'd3);
        tick();
        run_instr({1'b1, 4'b1001, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1}, 0, 16'h0, 0, 0, 3'd0, 16'h0);
        chk("add_cin", {16'd0, result}, 32'h10E1);
        chk_regs();
        tick();

        t0 = cyc;
        w = {1'b0, 4'b1110, 3'd7, 3'd2, 3'd3, 1'b0, 1'b1};
        run_instr({1'b0, 4'b0110, 3'd6, 3'd1, 3'd2, 1'b0, 1'b1}, 1, w, 0, 0, 3'd0, 16'h0);
        t1 = cyc;
        run_instr(w, 0, 16'h0, 0, 0, 3'd0, 16'h0);
        chk("hs_second_accept", 32'(t1 - t0), 32'd3);
        chk("hs_two_instr", 32'(cyc - t0), 32'd6);
        chk_regs();
        tick();

        run_instr({1'b0, 4'b1011, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0}, 0, 16'h0, 0, 1, 3'd6, 16'hBEEF);
        chk_regs();
        tick();
        load(3'd6, 16'hBEEF);
        dbg_addr = 3'd6;
        #1;
        chk("ld_idle_r6", {16'd0, dbg_data}, 32'hBEEF);
        tick();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) load(3'($urandom_range(0, 7)), 16'($urandom));
            run_instr(16'($urandom), 0, 16'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 16'($urandom));
            chk_regs();
            tick();
        end

        load(3'd1, 16'h1234);
        instr_valid = 1'b1;
        instr = {1'b0, 4'b1011, 3'd7, 3'd1, 3'd1, 1'b0, 1'b1};
        tick();
        instr_valid = 1'b0;
        chk("rst_pre_exec", {31'd0, instr_ready}, 32'd0);
        nd = ndone;
        rst = 1'b1;
        #1;
        chk("rst_async", {29'd0, instr_ready, done, carry_flag | cmp_flag}, 32'd4);
        model_reset();
        tick();
        rst = 1'b0;
        chk("rst_ready", {30'd0, instr_ready, done}, 32'd2);
        tick();
        tick();
        chk("rst_no_done", 32'(ndone - nd), 32'd0);
        chk("rst_flags", {14'd0, carry_flag, cmp_flag, result}, 32'd0);
        chk_regs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
